bats_pitch_encoder: RTL and testbench

Serializes order-book commands into BATS PITCH Sequenced Units on the 64-bit byte-enabled UDP payload stream that bats_parser_ip consumes. Each accepted command becomes one unit: an 8-byte Sequenced Unit Header followed by one message.
The block is the transmit-side counterpart of the parser. It is used as a hardware stimulus and loopback source and as a feed replay engine.
It sits between a command FIFO and the UDP transmit path.

---
 rtl/bats_pitch_encoder.sv | 178 +++++++++++++++++
 tb/tb_bats_pitch_encoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bats_pitch_encoder.sv
// BATS PITCH Sequenced Unit encoder: one command in, one header+message unit out on a 64-bit byte-enabled stream.
// Optional `BATS_ENC_AUTO_TIME_EN inserts a standalone Time unit whenever the command's seconds value changes.
module bats_pitch_encoder #(
   parameter logic [7:0]  UNIT_ID  = 8'h01,
   parameter logic [31:0] INIT_SEQ = 32'h00000001
) (
   input  logic        Clk40,
   input  logic        reset,
   input  logic        in_clear,
   input  logic        in_cmd_valid,
   output logic        out_cmd_ready,
   input  logic [7:0]  in_cmd_type,
   input  logic [31:0] in_seconds,
   input  logic [31:0] in_time_offset_ns,
   input  logic [63:0] in_order_id,
   input  logic [7:0]  in_side,
   input  logic [15:0] in_quantity,
   input  logic [47:0] in_symbol,
   input  logic [15:0] in_price,
   input  logic [31:0] in_executed_qty,
   input  logic [63:0] in_execution_id,
   input  logic        in_ready_for_output,
   output logic        out_data_valid,
   output logic [63:0] out_bytes,
   output logic [7:0]  out_byte_enables,
   output logic        out_bad_type
);

   typedef enum logic [1:0] {IDLE, SEND_TIME, SEND} state_t;

   function automatic logic [15:0] le16(input logic [15:0] x);
      return {x[7:0], x[15:8]};
   endfunction
   function automatic logic [31:0] le32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction
   function automatic logic [63:0] le64(input logic [63:0] x);
      return {le32(x[31:0]), le32(x[63:32])};
   endfunction

   state_t       r_state;
   logic         r_ready, r_valid, r_bad, r_tlast;
   logic [63:0]  r_bytes, r_tbeat;
   logic [7:0]   r_be, r_lbe;
   logic [31:0]  r_seq;
   logic [319:0] r_buf;
   logic [2:0]   r_left, r_nb;

   logic [319:0] w_unit;
   logic         w_known, w_ins;
   logic [2:0]   w_nb;
   logic [7:0]   w_lbe;

   // Unit image with byte 0 at the top; the sequence field is left zero and spliced in at send time.
   always_comb begin
      w_unit  = '0;
      w_known = 1'b1;
      w_nb    = 3'd5;
      w_lbe   = 8'hC0;
      case (in_cmd_type)
         8'h20: begin
            w_unit[319:192] = {8'h0E, 8'h00, 8'h01, UNIT_ID, 32'h0, 8'h06, 8'h20, le32(in_seconds), 16'h0};
            w_nb  = 3'd2;
            w_lbe = 8'hFC;
         end
         8'h22: w_unit[319:48] = {8'h22, 8'h00, 8'h01, UNIT_ID, 32'h0, 8'h1A, 8'h22, le32(in_time_offset_ns),
                                  le64(in_order_id), in_side, le16(in_quantity), in_symbol, le16(in_price), 8'h00};
         8'h23: w_unit[319:48] = {8'h22, 8'h00, 8'h01, UNIT_ID, 32'h0, 8'h1A, 8'h23, le32(in_time_offset_ns),
                                  le64(in_order_id), le32(in_executed_qty), le64(in_execution_id)};
         8'h29: begin
            w_unit[319:144] = {8'h16, 8'h00, 8'h01, UNIT_ID, 32'h0, 8'h0E, 8'h29, le32(in_time_offset_ns),
                               le64(in_order_id)};
            w_nb  = 3'd3;
            w_lbe = 8'hFC;
         end
         default: w_known = 1'b0;
      endcase
   end

`ifdef BATS_ENC_AUTO_TIME_EN
   logic [31:0] r_lsec;
   logic        r_lsec_vld;
   assign w_ins = w_known && (in_cmd_type != 8'h20) && (!r_lsec_vld || in_seconds != r_lsec);
   always_ff @(posedge Clk40 or posedge reset) begin
      if (reset) begin
         r_lsec     <= '0;
         r_lsec_vld <= 1'b0;
      end else if (in_clear) begin
         r_lsec_vld <= 1'b0;
      end else if (r_state == IDLE && r_ready && in_cmd_valid && (in_cmd_type == 8'h20 || w_ins)) begin
         r_lsec     <= in_seconds;
         r_lsec_vld <= 1'b1;
      end
   end
`else
   assign w_ins = 1'b0;
`endif

   always_ff @(posedge Clk40 or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;  r_ready <= 1'b0;  r_valid <= 1'b0;  r_bad <= 1'b0;
         r_bytes <= '0;    r_be    <= '0;    r_seq   <= INIT_SEQ;
         r_buf   <= '0;    r_left  <= '0;    r_nb    <= '0;    r_lbe <= '0;
         r_tbeat <= '0;    r_tlast <= 1'b0;
      end else if (in_clear) begin
         r_state <= IDLE;  r_ready <= 1'b0;  r_valid <= 1'b0;  r_bad <= 1'b0;
         r_bytes <= '0;    r_be    <= '0;    r_seq   <= INIT_SEQ;
      end else begin
         r_bad <= 1'b0;
         case (r_state)
            IDLE: begin
               r_ready <= 1'b1;
               if (in_cmd_valid && r_ready) begin
                  if (!w_known) begin
                     r_bad <= 1'b1;
                  end else begin
                     r_ready <= 1'b0;
                     r_valid <= 1'b1;
                     r_be    <= 8'hFF;
                     r_nb    <= w_nb;
                     r_lbe   <= w_lbe;
                     if (w_ins) begin
                        r_state <= SEND_TIME;
                        r_buf   <= w_unit;
                        r_bytes <= {8'h0E, 8'h00, 8'h01, UNIT_ID, le32(r_seq)};
                        r_tbeat <= {8'h06, 8'h20, le32(in_seconds), 16'h0};
                        r_tlast <= 1'b0;
                     end else begin
                        r_state <= SEND;
                        r_bytes <= {w_unit[319:288], le32(r_seq)};
                        r_buf   <= w_unit << 64;
                        r_left  <= w_nb - 3'd1;
                     end
                  end
               end
            end
            SEND_TIME: if (in_ready_for_output) begin
               if (!r_tlast) begin
                  r_bytes <= r_tbeat;
                  r_be    <= 8'hFC;
                  r_tlast <= 1'b1;
               end else begin
                  // Time unit done: it took r_seq, so the message header carries the next number.
                  r_seq   <= r_seq + 32'd1;
                  r_state <= SEND;
                  r_bytes <= {r_buf[319:288], le32(r_seq + 32'd1)};
                  r_be    <= 8'hFF;
                  r_buf   <= r_buf << 64;
                  r_left  <= r_nb - 3'd1;
               end
            end
            SEND: if (in_ready_for_output) begin
               if (r_left == 3'd0) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_valid <= 1'b0;
                  r_bytes <= '0;
                  r_be    <= '0;
                  r_seq   <= r_seq + 32'd1;
               end else begin
                  r_bytes <= r_buf[319:256];
                  r_buf   <= r_buf << 64;
                  r_left  <= r_left - 3'd1;
                  r_be    <= (r_left == 3'd1) ? r_lbe : 8'hFF;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_cmd_ready    = r_ready;
   assign out_data_valid   = r_valid;
   assign out_bytes        = r_bytes;
   assign out_byte_enables = r_be;
   assign out_bad_type     = r_bad;

endmodule

// File: tb/tb_bats_pitch_encoder.sv
// Randomized bench for bats_pitch_encoder: a byte-array unit model feeds a beat scoreboard.
module tb_bats_pitch_encoder;
   localparam logic [7:0]  UID  = 8'h01;
   localparam logic [31:0] INIT = 32'hFFFFFFFE;

   logic        Clk40 = 1'b0, reset = 1'b1, in_clear = 1'b0, in_cmd_valid = 1'b0, in_ready_for_output = 1'b1;
   logic        out_cmd_ready, out_data_valid, out_bad_type;
   logic [7:0]  in_cmd_type = '0, in_side = '0, out_byte_enables;
   logic [31:0] in_seconds = '0, in_time_offset_ns = '0, in_executed_qty = '0;
   logic [63:0] in_order_id = '0, in_execution_id = '0, out_bytes;
   logic [15:0] in_quantity = '0, in_price = '0;
   logic [47:0] in_symbol = '0;

   bats_pitch_encoder #(.UNIT_ID(UID), .INIT_SEQ(INIT)) dut (
      .Clk40(Clk40), .reset(reset), .in_clear(in_clear), .in_cmd_valid(in_cmd_valid),
      .out_cmd_ready(out_cmd_ready), .in_cmd_type(in_cmd_type), .in_seconds(in_seconds),
      .in_time_offset_ns(in_time_offset_ns), .in_order_id(in_order_id), .in_side(in_side),
      .in_quantity(in_quantity), .in_symbol(in_symbol), .in_price(in_price),
      .in_executed_qty(in_executed_qty), .in_execution_id(in_execution_id),
      .in_ready_for_output(in_ready_for_output), .out_data_valid(out_data_valid),
      .out_bytes(out_bytes), .out_byte_enables(out_byte_enables), .out_bad_type(out_bad_type));

   initial forever #5 Clk40 = ~Clk40;

   typedef struct packed {logic [63:0] d; logic [7:0] be;} beat_t;
   beat_t       q[$];
   logic [7:0]  ub [0:39];
   logic [31:0] mseq = INIT, lsec = '0;
   logic        lsv = 1'b0;
   int          nvec = 0, nerr = 0, exp_bad = 0, bad_seen = 0, nbeat = 0, rdy_mode = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic put_le(input int pos, input logic [63:0] v, input int n);
      for (int k = 0; k < n; k++) ub[pos+k] = v[8*k +: 8];
   endtask

   task automatic clr_ub;
      for (int i = 0; i < 40; i++) ub[i] = 8'h00;
   endtask

   // Fill the header from the model counter, then slice the unit into 8-byte beats.
   task automatic push_unit(input int len);
      beat_t b;
      ub[0] = len[7:0]; ub[1] = 8'h00; ub[2] = 8'h01; ub[3] = UID;
      put_le(4, {32'h0, mseq}, 4);
      for (int i = 0; i < (len + 7) / 8; i++) begin
         b = '0;
         for (int k = 0; k < 8; k++)
            if (8*i + k < len) begin
               b.d[63-8*k -: 8] = ub[8*i+k];
               b.be[7-k] = 1'b1;
            end
         q.push_back(b);
      end
      mseq = mseq + 32'd1;
   endtask

   task automatic time_unit(input logic [31:0] s);
      clr_ub; ub[8] = 8'h06; ub[9] = 8'h20; put_le(10, {32'h0, s}, 4);
      push_unit(14);
   endtask

   task automatic model_cmd;
      if (in_cmd_type != 8'h20 && in_cmd_type != 8'h22 && in_cmd_type != 8'h23 && in_cmd_type != 8'h29) begin
         exp_bad++;
         return;
      end
`ifdef BATS_ENC_AUTO_TIME_EN
      if (in_cmd_type != 8'h20 && (!lsv || in_seconds != lsec)) time_unit(in_seconds);
      lsv = 1'b1; lsec = in_seconds;
`endif
      clr_ub;
      ub[9] = in_cmd_type;
      put_le(10, {32'h0, in_time_offset_ns}, 4);
      case (in_cmd_type)
         8'h20: time_unit(in_seconds);
         8'h22: begin
            ub[8] = 8'h1A; put_le(14, in_order_id, 8); ub[22] = in_side;
            put_le(23, {48'h0, in_quantity}, 2);
            for (int k = 0; k < 6; k++) ub[25+k] = in_symbol[47-8*k -: 8];
            put_le(31, {48'h0, in_price}, 2);
            push_unit(34);
         end
         8'h23: begin
            ub[8] = 8'h1A; put_le(14, in_order_id, 8);
            put_le(22, {32'h0, in_executed_qty}, 4); put_le(26, in_execution_id, 8);
            push_unit(34);
         end
         default: begin
            ub[8] = 8'h0E; put_le(14, in_order_id, 8);
            push_unit(22);
         end
      endcase
   endtask

   task automatic model_reset;
      q.delete(); mseq = INIT; lsv = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the acceptance edge.
   task automatic send_cmd(input logic [7:0] t, input logic [31:0] sec);
      int n = 0;
      in_cmd_type = t; in_seconds = sec;
      in_time_offset_ns = $urandom; in_order_id = {$urandom, $urandom};
      in_side = ($urandom % 2) ? 8'h42 : 8'h53; in_quantity = 16'($urandom);
      in_symbol = {$urandom, 16'($urandom)}; in_price = 16'($urandom);
      in_executed_qty = $urandom; in_execution_id = {$urandom, $urandom};
      in_cmd_valid = 1'b1;
      while (!out_cmd_ready && n < 2000) begin @(negedge Clk40); n++; end
      if (n >= 2000) chk("accept_timeout", 64'(n), 64'd0);
      else model_cmd;
      @(negedge Clk40);
      in_cmd_valid = 1'b0;
   endtask

   task automatic drain;
      int n = 0;
      while ((q.size() != 0 || out_data_valid) && n < 1000) begin @(negedge Clk40); n++; end
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   initial forever begin
      @(posedge Clk40); #2;
      case (rdy_mode)
         0: in_ready_for_output = 1'b1;
         1: in_ready_for_output = ~in_ready_for_output;
         default: in_ready_for_output = ($urandom % 3) != 0;
      endcase
   end

   logic        prev_stall = 1'b0;
   logic [63:0] prev_d;
   logic [7:0]  prev_be;
   beat_t       eb;
   always @(negedge Clk40) begin
      if (reset || in_clear) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("hold_valid", {63'h0, out_data_valid}, 64'd1);
            chk("hold_data", out_bytes, prev_d);
            chk("hold_be", {56'h0, out_byte_enables}, {56'h0, prev_be});
         end
         if (out_data_valid && in_ready_for_output) begin
            nbeat++;
            if (q.size() == 0) chk("extra_beat", out_bytes, 64'h0);
            else begin
               eb = q.pop_front();
               chk("beat_data", out_bytes, eb.d);
               chk("beat_be", {56'h0, out_byte_enables}, {56'h0, eb.be});
            end
         end
         if (out_bad_type) bad_seen++;
         prev_stall = out_data_valid && !in_ready_for_output;
         prev_d = out_bytes; prev_be = out_byte_enables;
      end
   end

   initial begin
      int st;
      #1;
      chk("rst_valid", {63'h0, out_data_valid}, 64'd0);
      chk("rst_bytes", out_bytes, 64'd0);
      chk("rst_be", {56'h0, out_byte_enables}, 64'd0);
      chk("rst_ready", {63'h0, out_cmd_ready}, 64'd0);
      chk("rst_bad", {63'h0, out_bad_type}, 64'd0);
      @(posedge Clk40); #1 reset = 1'b0;
      @(negedge Clk40); @(negedge Clk40);
      chk("idle_ready", {63'h0, out_cmd_ready}, 64'd1);

      // Directed: Time, Add, then Exec/Delete with a toggling ready, then an unknown type.
      send_cmd(8'h20, 32'h0006D219); drain;
      send_cmd(8'h22, 32'd5); drain;
      send_cmd(8'h22, 32'd5); drain;
      rdy_mode = 1;
      send_cmd(8'h23, 32'd5); send_cmd(8'h29, 32'd5); drain;
      send_cmd(8'h55, 32'd5);
      repeat (3) @(negedge Clk40);
      chk("bad_no_valid", {63'h0, out_data_valid}, 64'd0);
      send_cmd(8'h29, 32'd5); drain;

      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         case ($urandom % 6)
            0: send_cmd(8'h20, 32'd5 + ($urandom % 2));
            1: send_cmd(8'h22, 32'd5 + ($urandom % 2));
            2: send_cmd(8'h23, 32'd5 + ($urandom % 2));
            3: send_cmd(8'h29, 32'd5 + ($urandom % 2));
            4: send_cmd(8'h55, 32'd5);
            default: send_cmd(8'($urandom), 32'd6);
         endcase
         repeat ($urandom % 3) @(negedge Clk40);
      end
      drain;

      // Async reset two beats into a five-beat unit.
      rdy_mode = 0;
      send_cmd(8'h22, 32'd7);
      st = nbeat;
      for (int n = 0; n < 50 && nbeat < st + 2; n++) @(negedge Clk40);
      @(posedge Clk40); #1 reset = 1'b1;
      #1;
      chk("arst_valid", {63'h0, out_data_valid}, 64'd0);
      chk("arst_bytes", out_bytes, 64'd0);
      model_reset;
      @(posedge Clk40); #1 reset = 1'b0;
      @(negedge Clk40);
      send_cmd(8'h29, 32'd7); drain;

      // Synchronous clear mid-unit.
      send_cmd(8'h23, 32'd8);
      @(negedge Clk40);
      in_clear = 1'b1;
      @(negedge Clk40);
      in_clear = 1'b0;
      model_reset;
      chk("clr_valid", {63'h0, out_data_valid}, 64'd0);
      chk("clr_ready", {63'h0, out_cmd_ready}, 64'd0);
      send_cmd(8'h29, 32'd8); send_cmd(8'h20, 32'd9); drain;

      chk("bad_count", 64'(bad_seen), 64'(exp_bad));
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
